// File: rtl/mpadd_pkg.sv
// Shared constants and types for the multi-precision add/subtract sequencer.
package mpadd_pkg;

  localparam int W = 32;

  localparam logic [7:0] CARRY_KILL = 8'h6B;
  localparam logic [7:0] CARRY_GEN  = 8'h67;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Any code other than "g" collapses to "k" so a corrupted code cannot propagate.
  function automatic logic [7:0] carry_norm(input logic [7:0] code);
    return (code == CARRY_GEN) ? CARRY_GEN : CARRY_KILL;
  endfunction

endpackage

// File: rtl/mpadd_seq_adder.sv
// 32-bit word adder with ASCII-coded carry in/out ("k" = 0, "g" = 1).
module mpadd_seq_adder
  import mpadd_pkg::*;
(
  output logic [W-1:0] sum,
  output logic [7:0]   cout,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [7:0]   cin
);

  logic [W:0] full;

  assign full = {1'b0, a} + {1'b0, b} + (W+1)'(cin == CARRY_GEN);
  assign sum  = full[W-1:0];
  assign cout = full[W] ? CARRY_GEN : CARRY_KILL;

endmodule

// File: rtl/mpadd_seq.sv
// Multi-precision add/subtract sequencer: one shared word adder, LSW first, carry chained.
module mpadd_seq #(
  parameter int WORDS = 4,
  parameter int W     = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               op_sub,
  input  logic [WORDS*W-1:0] a,
  input  logic [WORDS*W-1:0] b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WORDS*W-1:0] sum,
  output logic [7:0]         carry_out,
  output logic               overflow
);

  import mpadd_pkg::*;

  localparam int IDX_W = $clog2(WORDS);
  localparam int TOP   = WORDS*W-1;

  state_t             state, state_nx;
  logic [WORDS*W-1:0] a_reg, b_reg;
  logic [7:0]         carry_reg;
  logic [IDX_W-1:0]   idx;
  logic [W-1:0]       add_a, add_b, add_sum;
  logic [7:0]         add_cout;
  logic               last;

  assign add_a = a_reg[idx*W +: W];
  assign add_b = b_reg[idx*W +: W];
  assign last  = (idx == IDX_W'(WORDS-1));

  mpadd_seq_adder adder_0 (
    .sum  (add_sum),
    .cout (add_cout),
    .a    (add_a),
    .b    (add_b),
    .cin  (carry_reg)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)  state_nx = RUN;
      RUN:     if (last)      state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= CARRY_KILL;
      idx       <= '0;
      sum       <= '0;
      carry_out <= CARRY_KILL;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= a;
            b_reg     <= op_sub ? ~b : b;
            carry_reg <= op_sub ? CARRY_GEN : CARRY_KILL;
            idx       <= '0;
          end
        end
        RUN: begin
          sum[idx*W +: W] <= add_sum;
          carry_reg       <= carry_norm(add_cout);
          idx             <= idx + IDX_W'(1);
          // b_reg already holds ~b for subtract, so one overflow rule covers both ops.
          if (last) begin
            carry_out <= carry_norm(add_cout);
            overflow  <= (a_reg[TOP] == b_reg[TOP]) && (add_sum[W-1] != a_reg[TOP]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mpadd_seq.sv
// Directed-vector bench for mpadd_seq with WORDS=4.
module tb_mpadd_seq;

  localparam logic [7:0] K = 8'h6B;
  localparam logic [7:0] G = 8'h67;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         op_sub;
  logic [127:0] a, b;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] sum;
  logic [7:0]   carry_out;
  logic         overflow;

  int nvec = 0;
  int nerr = 0;
  int lat;

  always #5 clk = ~clk;

  mpadd_seq #(.WORDS(4), .W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_sub    (op_sub),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Accept one request and wait (bounded) for out_valid; lat = cycles after accept.
  task automatic start(input logic [127:0] av, input logic [127:0] bv, input logic sub);
    @(negedge clk);
    a = av; b = bv; op_sub = sub; in_valid = 1'b1;
    check("in_ready_before_accept", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    check("latency", lat, 4);
  endtask

  task automatic result(input string tag, input logic [127:0] es, input logic [7:0] ec,
                        input logic eo);
    check({tag, "_sum"}, sum, es);
    check({tag, "_carry"}, carry_out, ec);
    check({tag, "_carry_legal"}, (carry_out == K || carry_out == G), 1);
    check({tag, "_ovf"}, overflow, eo);
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; op_sub = 1'b0; a = 128'd9; b = 128'd9; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; in_valid = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_carry", carry_out, K);
    check("rst_ovf", overflow, 0);

    start(128'd1, 128'hFFFF_FFFF, 1'b0);
    result("chain", 128'h1_0000_0000, K, 1'b0);
    release_result();

    start({128{1'b1}}, 128'd1, 1'b0);
    result("wrap", 128'd0, G, 1'b0);
    release_result();

    start(128'd5, 128'd7, 1'b0 | 1'b1);
    result("sub_borrow", 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE, K, 1'b0);
    release_result();

    start(128'd7, 128'd5, 1'b1);
    result("sub_noborrow", 128'd2, G, 1'b0);
    release_result();

    start(128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'd1, 1'b0);
    result("sovf", 128'h8000_0000_0000_0000_0000_0000_0000_0000, K, 1'b1);
    release_result();

    // Backpressure: result must hold while a new request is ignored.
    out_ready = 1'b0;
    start(128'h0000_0001_0000_0002_0000_0003_0000_0004,
          128'h0000_0010_0000_0020_0000_0030_0000_0040, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a = 128'd9; b = 128'd9; op_sub = 1'b0; in_valid = (i == 1);
      @(posedge clk);
      #1;
      check("bp_sum", sum, 128'h0000_0011_0000_0022_0000_0033_0000_0044);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    release_result();
    check("bp_idle_ready", in_ready, 1);
    check("bp_idle_valid", out_valid, 0);
    start(128'd100, 128'd28, 1'b1);
    result("bp_fresh", 128'd72, G, 1'b0);
    release_result();

    // Reset while idx==2: abort, then a clean request.
    @(negedge clk);
    a = 128'd1; b = 128'd1; op_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_sum", sum, 0);
    start(128'd3, 128'd4, 1'b0);
    result("after_rst", 128'd7, K, 1'b0);
    release_result();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
